// File: rtl/tlul_prog_loader.sv
// Program loader: assembles a UART byte stream into 32-bit words and writes
// them over TL-UL (PutFullData), holding the core in reset until loading ends.

package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_prog_loader #(
  parameter logic [31:0] BaseAddr = 32'h2000_0000,
  parameter logic [31:0] EndWord  = 32'h0000_0FFF,
  parameter int unsigned MaxWords = 1024
) (
  input  logic               clock,
  input  logic               rst_ni,
  input  logic               rx_dv_i,
  input  logic [7:0]         rx_byte_i,
  output tlul_pkg::tl_h2d_t  tl_o,
  input  tlul_pkg::tl_d2h_t  tl_i,
  output logic               core_hold_o,
  output logic               done_o,
  output logic               err_o,
  output logic               overrun_o,
  output logic [15:0]        word_cnt_o
);

  import tlul_pkg::*;

  localparam logic [15:0] MaxCnt = MaxWords[15:0];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP,
    ST_DONE
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;

  logic [1:0]  r_byte_idx;
  logic [23:0] r_shift;

  logic        r_pend_valid;
  logic [31:0] r_pend_addr;
  logic [31:0] r_pend_data;
  logic [31:0] r_addr;
  logic        r_end_req;

  logic [31:0] r_a_addr;
  logic [31:0] r_a_data;
  logic [1:0]  r_a_size;
  logic [3:0]  r_a_mask;
  logic        r_d_ready;

  logic [15:0] r_word_cnt;
  logic        r_err;
  logic        r_overrun;

  logic        w_byte_en;
  logic        w_word_done;
  logic [31:0] w_word;
  logic        w_is_end;
  logic        w_load_a;
  logic        w_ack;
  logic        w_pend_load;
  logic        w_overrun;
  logic [15:0] w_cnt_inc;

  assign w_byte_en   = rx_dv_i && (r_state != ST_DONE);
  assign w_word_done = w_byte_en && (r_byte_idx == 2'd3);
  assign w_word      = {rx_byte_i, r_shift};
  assign w_is_end    = (w_word == EndWord);
  assign w_cnt_inc   = r_word_cnt + 16'd1;

  // A word may land in pending on the same cycle IDLE drains it.
  assign w_pend_load = w_word_done && !w_is_end && (!r_pend_valid || w_load_a);
  assign w_overrun   = w_word_done && !w_is_end && r_pend_valid && !w_load_a;

  // Bytes shift in from the top so byte 0 ends up in [7:0].
  always_ff @(posedge clock or negedge rst_ni) begin
    if (!rst_ni) begin
      r_byte_idx <= 2'd0;
      r_shift    <= 24'd0;
    end else if (w_byte_en) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of process ordering.
      r_byte_idx <= r_byte_idx + 2'd1;
      r_shift    <= {rx_byte_i, r_shift[23:8]};
    end
  end

  // NOTE: payload registers are reset (not left as plain storage) because the
  // bus fields must read 0 while the loader is in reset.
  always_ff @(posedge clock or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= 32'd0;
      r_pend_data  <= 32'd0;
      r_addr       <= BaseAddr;
      r_end_req    <= 1'b0;
    end else begin
      if (w_pend_load) begin
        r_pend_valid <= 1'b1;
        r_pend_addr  <= r_addr;
        r_pend_data  <= w_word;
        r_addr       <= r_addr + 32'd4;
      end else if (w_load_a) begin
        r_pend_valid <= 1'b0;
      end
      if (w_word_done && w_is_end) begin
        r_end_req <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_ack       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_pend_valid) begin
          w_load_a    = 1'b1;
          w_state_nxt = ST_REQ;
        end else if (r_end_req) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_REQ: begin
        if (tl_i.a_ready) begin
          w_state_nxt = ST_RSP;
        end
      end
      ST_RSP: begin
        if (tl_i.d_valid) begin
          w_ack       = 1'b1;
          w_state_nxt = (w_cnt_inc == MaxCnt) ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a_addr  <= 32'd0;
      r_a_data  <= 32'd0;
      r_a_size  <= 2'd0;
      r_a_mask  <= 4'h0;
      r_d_ready <= 1'b0;
    end else begin
      r_d_ready <= 1'b1;
      if (w_load_a) begin
        r_a_addr <= r_pend_addr;
        r_a_data <= r_pend_data;
        r_a_size <= 2'd2;
        r_a_mask <= 4'hF;
      end
    end
  end

  // An errored response still counts as a written word.
  always_ff @(posedge clock or negedge rst_ni) begin
    if (!rst_ni) begin
      r_word_cnt <= 16'd0;
      r_err      <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_ack) begin
        if (r_word_cnt != MaxCnt) begin
          r_word_cnt <= w_cnt_inc;
        end
        if (tl_i.d_error) begin
          r_err <= 1'b1;
        end
      end
      if (w_overrun) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (r_state == ST_REQ);
    tl_o.a_opcode  = PutFullData;
    tl_o.a_param   = 3'd0;
    tl_o.a_size    = r_a_size;
    tl_o.a_source  = 8'd0;
    tl_o.a_address = r_a_addr;
    tl_o.a_mask    = r_a_mask;
    tl_o.a_data    = r_a_data;
    tl_o.a_user    = 16'd0;
    tl_o.d_ready   = r_d_ready;
  end

  assign done_o      = (r_state == ST_DONE);
  assign core_hold_o = !done_o;
  assign err_o       = r_err;
  assign overrun_o   = r_overrun;
  assign word_cnt_o  = r_word_cnt;

  // Response payload is not needed by a write-only initiator.
  logic w_unused_d;
  assign w_unused_d = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                        tl_i.d_sink, tl_i.d_data, tl_i.d_user};

endmodule

// File: tb/tb_tlul_prog_loader.sv
// Scoreboarded bench for tlul_prog_loader: a TL-UL responder model answers the
// writes, a monitor pops expected (address, data) pairs on each A handshake.

module tb_tlul_prog_loader;

  import tlul_pkg::*;

  localparam logic [31:0] END_W = 32'h0000_0FFF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_main_n, rst_mw_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        sel_mw;
  tl_h2d_t     tl_main, tl_mw, tl_h;
  tl_d2h_t     tl_d;
  logic        hold_main, done_main, err_main, ovr_main;
  logic        hold_mw, done_mw, err_mw, ovr_mw;
  logic [15:0] cnt_main, cnt_mw;

  tlul_prog_loader dut (
    .clock(clock), .rst_ni(rst_main_n), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte),
    .tl_o(tl_main), .tl_i(tl_d), .core_hold_o(hold_main), .done_o(done_main),
    .err_o(err_main), .overrun_o(ovr_main), .word_cnt_o(cnt_main)
  );

  tlul_prog_loader #(.MaxWords(2)) dut_mw (
    .clock(clock), .rst_ni(rst_mw_n), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte),
    .tl_o(tl_mw), .tl_i(tl_d), .core_hold_o(hold_mw), .done_o(done_mw),
    .err_o(err_mw), .overrun_o(ovr_mw), .word_cnt_o(cnt_mw)
  );

  // Only the selected DUT is out of reset; the other is held idle.
  logic        cur_rst_n, w_hold, w_done, w_err, w_ovr;
  logic [15:0] w_cnt;
  assign tl_h      = sel_mw ? tl_mw    : tl_main;
  assign cur_rst_n = sel_mw ? rst_mw_n : rst_main_n;
  assign w_hold    = sel_mw ? hold_mw  : hold_main;
  assign w_done    = sel_mw ? done_mw  : done_main;
  assign w_err     = sel_mw ? err_mw   : err_main;
  assign w_ovr     = sel_mw ? ovr_mw   : ovr_main;
  assign w_cnt     = sel_mw ? cnt_mw   : cnt_main;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   writes = 0;
  int   stall_cfg = 0;
  int   err_idx = -1;
  int   rsp_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick(1);
    rx_dv   = 1'b0;
    tick(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic reset_main();
    rst_main_n = 1'b0;
    rsp_idx    = 0;
    tick(3);
    rst_main_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while (!w_done && n < max) begin
      tick(1);
      n++;
    end
    check(name, 32'(w_done), 32'd1);
  endtask

  // Responder: a_ready after stall_cfg cycles of a_valid, d_valid the cycle after.
  initial begin : responder
    logic hs;
    int   stall_left;
    hs         = 1'b0;
    stall_left = 0;
    tl_d       = '0;
    forever begin
      @(negedge clock);
      hs = tl_h.a_valid && tl_d.a_ready;
      @(posedge clock);
      #1;
      if (!cur_rst_n) begin
        tl_d       = '0;
        stall_left = stall_cfg;
      end else begin
        tl_d.d_valid = hs;
        tl_d.d_error = hs && (rsp_idx == err_idx);
        if (hs) rsp_idx++;
        if (tl_h.a_valid) begin
          if (stall_left > 0) begin
            tl_d.a_ready = 1'b0;
            stall_left--;
          end else begin
            tl_d.a_ready = 1'b1;
          end
        end else begin
          tl_d.a_ready = 1'b0;
          stall_left   = stall_cfg;
        end
      end
    end
  end

  initial begin : monitor
    logic        stalled;
    logic [31:0] h_addr, h_data;
    exp_t        e;
    stalled = 1'b0;
    h_addr  = '0;
    h_data  = '0;
    forever begin
      @(negedge clock);
      if (!cur_rst_n || !tl_h.a_valid) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_addr_stable", tl_h.a_address, h_addr);
          check("stall_data_stable", tl_h.a_data, h_data);
        end
        if (tl_d.a_ready) begin
          stalled = 1'b0;
          writes++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual addr=%h data=%h required no write",
                     tl_h.a_address, tl_h.a_data);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", tl_h.a_address, e.addr);
            check("wr_data", tl_h.a_data, e.data);
            check("wr_mask", 32'(tl_h.a_mask), 32'hF);
            check("wr_size", 32'(tl_h.a_size), 32'd2);
            check("wr_opcode", 32'(tl_h.a_opcode), 32'(PutFullData));
            check("wr_param_src", {21'd0, tl_h.a_param, tl_h.a_source}, 32'd0);
          end
        end else begin
          stalled = 1'b1;
          h_addr  = tl_h.a_address;
          h_data  = tl_h.a_data;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int w_before;
    rst_main_n = 1'b0;
    rst_mw_n   = 1'b0;
    rx_dv      = 1'b0;
    rx_byte    = 8'h00;
    sel_mw     = 1'b0;
    tick(3);

    // Reset values
    check("rst_a_valid", 32'(tl_h.a_valid), 32'd0);
    check("rst_a_address", tl_h.a_address, 32'd0);
    check("rst_a_data", tl_h.a_data, 32'd0);
    check("rst_a_mask_size", {26'd0, tl_h.a_mask, tl_h.a_size}, 32'd0);
    check("rst_d_ready", 32'(tl_h.d_ready), 32'd0);
    check("rst_hold", 32'(w_hold), 32'd1);
    check("rst_flags", {29'd0, w_done, w_err, w_ovr}, 32'd0);
    check("rst_cnt", 32'(w_cnt), 32'd0);
    rst_main_n = 1'b1;
    tick(1);
    check("d_ready_after_rst", 32'(tl_h.d_ready), 32'd1);

    // T1: single word then end word, zero-wait responder, latency checks
    stall_cfg = 0;
    expect_write(32'h2000_0000, 32'h1234_5678);
    send_byte(8'h78, 2);
    send_byte(8'h56, 2);
    send_byte(8'h34, 2);
    send_byte(8'h12, 0);
    check("lat_a_valid_n1", 32'(tl_h.a_valid), 32'd0);
    tick(1);
    check("lat_a_valid_n2", 32'(tl_h.a_valid), 32'd1);
    tick(6);
    send_byte(8'hFF, 2);
    send_byte(8'h0F, 2);
    send_byte(8'h00, 2);
    send_byte(8'h00, 0);
    check("t1_done_n1", 32'(w_done), 32'd0);
    tick(1);
    check("t1_done_n2", 32'(w_done), 32'd1);
    check("t1_hold", 32'(w_hold), 32'd0);
    check("t1_cnt", 32'(w_cnt), 32'd1);
    check("t1_err_ovr", {30'd0, w_err, w_ovr}, 32'd0);

    // T2: three words, responder stalls a_ready 5 cycles each
    reset_main();
    stall_cfg = 5;
    expect_write(32'h2000_0000, 32'hA1B2_C3D4);
    expect_write(32'h2000_0004, 32'h0BAD_F00D);
    expect_write(32'h2000_0008, 32'hCAFE_BABE);
    send_word(32'hA1B2_C3D4, 2);
    send_word(32'h0BAD_F00D, 2);
    send_word(32'hCAFE_BABE, 2);
    send_word(END_W, 2);
    wait_done("t2_done", 200);
    check("t2_cnt", 32'(w_cnt), 32'd3);
    check("t2_err_ovr", {30'd0, w_err, w_ovr}, 32'd0);
    check("t2_all_written", 32'(exp_q.size()), 32'd0);

    // T3: error on the second response, loading continues
    reset_main();
    stall_cfg = 0;
    err_idx   = 1;
    expect_write(32'h2000_0000, 32'h1111_1111);
    expect_write(32'h2000_0004, 32'h2222_2222);
    expect_write(32'h2000_0008, 32'h3333_3333);
    send_word(32'h1111_1111, 2);
    check("t3_err_before", 32'(w_err), 32'd0);
    send_word(32'h2222_2222, 2);
    send_word(32'h3333_3333, 2);
    send_word(END_W, 2);
    wait_done("t3_done", 200);
    check("t3_err", 32'(w_err), 32'd1);
    check("t3_cnt", 32'(w_cnt), 32'd3);
    tick(10);
    check("t3_err_sticky", 32'(w_err), 32'd1);
    check("t3_all_written", 32'(exp_q.size()), 32'd0);
    err_idx = -1;

    // T4: bytes every cycle with a 20-cycle a_ready stall -> third word dropped
    reset_main();
    stall_cfg = 20;
    expect_write(32'h2000_0000, 32'h0302_0100);
    expect_write(32'h2000_0004, 32'h0706_0504);
    send_word(32'h0302_0100, 0);
    send_word(32'h0706_0504, 0);
    send_word(32'h0B0A_0908, 0);
    send_word(END_W, 0);
    wait_done("t4_done", 300);
    check("t4_overrun", 32'(w_ovr), 32'd1);
    check("t4_cnt", 32'(w_cnt), 32'd2);
    check("t4_all_written", 32'(exp_q.size()), 32'd0);

    // T6: reset asserted in REQ with a partial word assembled
    reset_main();
    stall_cfg = 50;
    send_word(32'hDEAD_BEEF, 0);
    tick(1);
    check("t6_in_req", 32'(tl_h.a_valid), 32'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst_main_n = 1'b0;
    #1;
    check("t6_async_a_valid", 32'(tl_h.a_valid), 32'd0);
    check("t6_async_hold", 32'(w_hold), 32'd1);
    check("t6_async_addr", tl_h.a_address, 32'd0);
    tick(2);
    stall_cfg  = 0;
    rsp_idx    = 0;
    rst_main_n = 1'b1;
    tick(1);
    expect_write(32'h2000_0000, 32'h55AA_55AA);
    send_word(32'h55AA_55AA, 2);
    send_word(END_W, 2);
    wait_done("t6_done", 200);
    check("t6_cnt", 32'(w_cnt), 32'd1);
    check("t6_all_written", 32'(exp_q.size()), 32'd0);

    // T5: MaxWords = 2 instance, third word ignored
    rst_main_n = 1'b0;
    sel_mw     = 1'b1;
    rsp_idx    = 0;
    stall_cfg  = 0;
    tick(2);
    rst_mw_n = 1'b1;
    tick(1);
    expect_write(32'h2000_0000, 32'hC0DE_0001);
    expect_write(32'h2000_0004, 32'hC0DE_0002);
    send_word(32'hC0DE_0001, 2);
    send_word(32'hC0DE_0002, 2);
    wait_done("t5_done", 100);
    check("t5_cnt", 32'(w_cnt), 32'd2);
    check("t5_hold", 32'(w_hold), 32'd0);
    w_before = writes;
    send_word(32'hC0DE_0003, 2);
    tick(20);
    check("t5_no_third_write", 32'(writes), 32'(w_before));
    check("t5_cnt_saturated", 32'(w_cnt), 32'd2);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
